// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the result-memory port arbiter.
package mem_arb_pkg;

    // Default memory geometry: 256 words of 32 bits.
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    // Encoding of the request/memory direction bit.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Every access is sequenced as IDLE (arbitrate) -> ACCESS -> RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// The master side is the requesters plus the memory; the slave side is the arbiter.
interface mem_port_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) ();

    logic [NREQ-1:0]        Req;
    logic [NREQ-1:0]        ReqRW;
    logic [NREQ*ADDR_W-1:0] ReqAddr;
    logic [NREQ*DATA_W-1:0] ReqWData;
    logic [NREQ-1:0]        Gnt;
    logic [NREQ-1:0]        Done;
    logic [DATA_W-1:0]      RData;
    logic                   Busy;
    logic                   MemAccess;
    logic                   MemRW;
    logic [ADDR_W-1:0]      MemAddr;
    logic [DATA_W-1:0]      MemWData;
    logic [DATA_W-1:0]      MemRData;

    modport master (
        output Req, ReqRW, ReqAddr, ReqWData, MemRData,
        input  Gnt, Done, RData, Busy, MemAccess, MemRW, MemAddr, MemWData
    );

    modport slave (
        input  Req, ReqRW, ReqAddr, ReqWData, MemRData,
        output Gnt, Done, RData, Busy, MemAccess, MemRW, MemAddr, MemWData
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// searching upward modulo NREQ.
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    logic [PTR_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = PTR_W'((int'(ptr_i) + i) % NREQ);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter owning the single-port result memory. Each winner gets
// one ACCESS cycle, one RESP cycle for the registered read data, then a Done pulse.
module mem_port_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input logic               Clk,
    input logic               Reset,
    mem_port_arbiter_if.slave bus
);

    import mem_arb_pkg::*;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [NREQ-1:0]     gnt;
    logic [PTR_W-1:0]    win_idx;
    logic                win_valid;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (bus.Req),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // Next-state, request latching and per-state outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = '0;
        gnt     = '0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ACCESS;
                    owner_d = win_idx;
                    rw_d    = bus.ReqRW[win_idx];
                    addr_d  = bus.ReqAddr[int'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_d = bus.ReqWData[int'(win_idx)*DATA_W +: DATA_W];
                    ptr_d   = PTR_W'((int'(win_idx) + 1) % NREQ);
                end
            end
            ACCESS: begin
                gnt[owner_q] = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                // The memory registers its read data, so it is only valid here.
                done_d[owner_q] = 1'b1;
                if (rw_q == RW_READ) begin
                    rdata_d = bus.MemRData;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign bus.Gnt       = gnt;
    assign bus.Done      = done_q;
    assign bus.RData     = rdata_q;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.MemAccess = (state_q == ACCESS);
    assign bus.MemRW     = rw_q;
    assign bus.MemAddr   = addr_q;
    assign bus.MemWData  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with four requesters and a 256x32
// memory model whose read data is registered one cycle after the access.
module tb_mem_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    always #5 Clk = ~Clk;

    mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int            idx;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_cyc;
    } gnt_item_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
    } done_item_t;

    gnt_item_t  gnt_q[$];
    done_item_t done_q[$];

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc;
    int            last_gnt_cyc = 0;
    logic [DW-1:0] last_rd = '0;

    // Memory: preloaded with word i = {4{i}}, then written/read on MemAccess.
    logic [DW-1:0] mem [256];
    bit            mem_init_done = 1'b0;

    always @(posedge Clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= {4{8'(i)}};
            mem_init_done <= 1'b1;
        end else if (bus.MemAccess) begin
            if (bus.MemRW) mem[bus.MemAddr] <= bus.MemWData;
            else           bus.MemRData     <= mem[bus.MemAddr];
        end
    end

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
    endtask

    task automatic push_gnt(int idx, logic rw, logic [AW-1:0] a, logic [DW-1:0] d, int c);
        gnt_item_t g;
        g.idx = idx; g.rw = rw; g.addr = a; g.wdata = d; g.exp_cyc = c;
        gnt_q.push_back(g);
    endtask

    // Reads return the given word; writes must leave RData at the last read value.
    task automatic push_done(int idx, logic rw, logic [DW-1:0] v);
        done_item_t d;
        d.idx = idx;
        if (!rw) last_rd = v;
        d.rdata = last_rd;
        done_q.push_back(d);
    endtask

    // Monitor: compares every grant and completion against the scoreboard.
    gnt_item_t       mon_g;
    done_item_t      mon_d;
    logic [NREQ-1:0] exp_vec;
    logic [NREQ-1:0] prev_gnt  = '0;
    logic [NREQ-1:0] prev_done = '0;

    always @(negedge Clk) begin
        if (Reset) begin
            if (bus.Gnt != '0 || bus.MemAccess) begin
                check("gnt_single_cycle", 64'(prev_gnt), 64'(0));
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 64'(bus.Gnt), 64'(0));
                end else begin
                    mon_g = gnt_q.pop_front();
                    exp_vec = '0;
                    exp_vec[mon_g.idx] = 1'b1;
                    check("gnt_vec", 64'(bus.Gnt), 64'(exp_vec));
                    check("mem_access", 64'(bus.MemAccess), 64'(1));
                    check("busy_access", 64'(bus.Busy), 64'(1));
                    check("mem_rw", 64'(bus.MemRW), 64'(mon_g.rw));
                    check("mem_addr", 64'(bus.MemAddr), 64'(mon_g.addr));
                    if (mon_g.rw) check("mem_wdata", 64'(bus.MemWData), 64'(mon_g.wdata));
                    if (mon_g.exp_cyc >= 0) check("gnt_cycle", 64'(cyc), 64'(mon_g.exp_cyc));
                    last_gnt_cyc = cyc;
                end
            end
            if (bus.Done != '0) begin
                check("done_single_cycle", 64'(prev_done), 64'(0));
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(bus.Done), 64'(0));
                end else begin
                    mon_d = done_q.pop_front();
                    exp_vec = '0;
                    exp_vec[mon_d.idx] = 1'b1;
                    check("done_vec", 64'(bus.Done), 64'(exp_vec));
                    check("rdata", 64'(bus.RData), 64'(mon_d.rdata));
                    check("done_latency", 64'(cyc), 64'(last_gnt_cyc + 2));
                    check("busy_done", 64'(bus.Busy), 64'(0));
                end
            end
        end
        prev_gnt  = bus.Gnt;
        prev_done = bus.Done;
    end

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(posedge Clk); #1;
            if (gnt_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("drain");
    endtask

    // Hold a request mask until n grants have been seen, then release it.
    task automatic wait_grants(int n);
        int cnt = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge Clk); #1;
            if (bus.Gnt != '0) cnt++;
            if (cnt == n) break;
        end
        bus.Req = '0;
        if (cnt < n) timeout("burst_grants");
        wait_drain();
    endtask

    // One transaction from an idle arbiter; alt values are applied in RESP.
    task automatic do_req(int idx, logic rw, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                          logic [AW-1:0] alt, logic [DW-1:0] exp_rd);
        bit seen = 1'b0;
        bus.ReqRW[idx]               = rw;
        bus.ReqAddr[idx*AW +: AW]    = addr;
        bus.ReqWData[idx*DW +: DW]   = wdata;
        push_gnt(idx, rw, addr, wdata, cyc + 1);
        push_done(idx, rw, exp_rd);
        bus.Req[idx] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge Clk); #1;
            if (bus.Gnt[idx]) begin
                seen = 1'b1;
                break;
            end
        end
        bus.Req[idx] = 1'b0;
        if (!seen) timeout("gnt_wait");
        @(posedge Clk); #1;
        bus.ReqAddr[idx*AW +: AW]  = alt;
        bus.ReqWData[idx*DW +: DW] = ~wdata;
        bus.ReqRW[idx]             = ~rw;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.Req      = '0;
        bus.ReqRW    = '0;
        bus.ReqWData = '0;
        for (int i = 0; i < NREQ; i++) bus.ReqAddr[i*AW +: AW] = 8'(i + 1);

        repeat (3) @(posedge Clk);
        #1;
        check("rst_gnt", 64'(bus.Gnt), 64'(0));
        check("rst_done", 64'(bus.Done), 64'(0));
        check("rst_rdata", 64'(bus.RData), 64'(0));
        check("rst_busy", 64'(bus.Busy), 64'(0));
        check("rst_mem_access", 64'(bus.MemAccess), 64'(0));
        check("rst_mem_rw", 64'(bus.MemRW), 64'(0));
        check("rst_mem_addr", 64'(bus.MemAddr), 64'(0));
        check("rst_mem_wdata", 64'(bus.MemWData), 64'(0));

        // Contention from reset: grants 0,1,0,1 on cycles 1,4,7,10.
        push_gnt(0, 1'b0, 8'h01, '0, 1);  push_done(0, 1'b0, 32'h01010101);
        push_gnt(1, 1'b0, 8'h02, '0, 4);  push_done(1, 1'b0, 32'h02020202);
        push_gnt(0, 1'b0, 8'h01, '0, 7);  push_done(0, 1'b0, 32'h01010101);
        push_gnt(1, 1'b0, 8'h02, '0, 10); push_done(1, 1'b0, 32'h02020202);
        bus.Req = 4'b0011;
        Reset   = 1'b1;
        wait_grants(4);

        // Ptr=2 with Req=0011: wrap to 0, then Ptr=1 gives 1.
        push_gnt(0, 1'b0, 8'h01, '0, -1); push_done(0, 1'b0, 32'h01010101);
        push_gnt(1, 1'b0, 8'h02, '0, -1); push_done(1, 1'b0, 32'h02020202);
        bus.Req = 4'b0011;
        wait_grants(2);

        // Ptr=2 with Req=1101: 2, 3, then wrap to 0.
        push_gnt(2, 1'b0, 8'h03, '0, -1); push_done(2, 1'b0, 32'h03030303);
        push_gnt(3, 1'b0, 8'h04, '0, -1); push_done(3, 1'b0, 32'h04040404);
        push_gnt(0, 1'b0, 8'h01, '0, -1); push_done(0, 1'b0, 32'h01010101);
        bus.Req = 4'b1101;
        wait_grants(3);

        // Write then read back.
        do_req(0, 1'b1, 8'h10, 32'hDEADBEEF, 8'h10, '0);
        do_req(0, 1'b0, 8'h10, 32'h0, 8'h10, 32'hDEADBEEF);

        // Owner inputs change in RESP; the transaction must keep 0x20.
        do_req(1, 1'b0, 8'h20, 32'h0, 8'h30, 32'h20202020);

        // Reset during RESP of a read.
        bus.ReqRW[0]            = 1'b0;
        bus.ReqAddr[0*AW +: AW] = 8'h10;
        push_gnt(0, 1'b0, 8'h10, '0, cyc + 1);
        bus.Req[0] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge Clk); #1;
            if (bus.Gnt[0]) begin
                seen = 1'b1;
                break;
            end
        end
        bus.Req[0] = 1'b0;
        if (!seen) timeout("gnt_wait_rst");
        @(posedge Clk); #1;
        check("resp_busy", 64'(bus.Busy), 64'(1));
        check("resp_mem_access", 64'(bus.MemAccess), 64'(0));
        Reset = 1'b0;
        #1;
        check("midrst_gnt", 64'(bus.Gnt), 64'(0));
        check("midrst_done", 64'(bus.Done), 64'(0));
        check("midrst_busy", 64'(bus.Busy), 64'(0));
        check("midrst_mem_access", 64'(bus.MemAccess), 64'(0));
        check("midrst_rdata", 64'(bus.RData), 64'(0));
        check("midrst_mem_rw", 64'(bus.MemRW), 64'(0));
        check("midrst_mem_addr", 64'(bus.MemAddr), 64'(0));
        check("midrst_mem_wdata", 64'(bus.MemWData), 64'(0));
        last_rd = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge Clk); #1;
            check("post_rst_busy", 64'(bus.Busy), 64'(0));
            check("post_rst_done", 64'(bus.Done), 64'(0));
        end

        // Normal operation after reset.
        do_req(1, 1'b1, 8'h40, 32'hCAFEF00D, 8'h41, '0);
        do_req(1, 1'b0, 8'h40, 32'h0, 8'h41, 32'hCAFEF00D);

        // Idle hold after a read of 0x12345678.
        do_req(2, 1'b1, 8'h44, 32'h12345678, 8'h44, '0);
        do_req(3, 1'b0, 8'h44, 32'h0, 8'h44, 32'h12345678);
        for (int t = 0; t < 20; t++) begin
            @(posedge Clk); #1;
            check("idle_busy", 64'(bus.Busy), 64'(0));
            check("idle_mem_access", 64'(bus.MemAccess), 64'(0));
            check("idle_rdata", 64'(bus.RData), 64'(32'h12345678));
        end

        check("gnt_queue_left", 64'(gnt_q.size()), 64'(0));
        check("done_queue_left", 64'(done_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single-port 256×32 result memory between several requesters, for example the calculation/store path and the serial readout path. It sequences every access as a fixed three-phase transaction and drives the memory's access-enable, read/write, address and write-data inputs. It returns read data and a completion pulse to the winning requester. It sits between the requesters and the memory instance, and replaces direct drive of the memory's access and read/write controls by a single controller.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 8, memory address width
- DATA_W, 32, memory data width

Ports (clock and reset first):
- Clk  in  1  single clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- Req  in  NREQ  per-requester request level
- ReqRW  in  NREQ  per-requester direction: 1 = write, 0 = read
- ReqAddr  in  NREQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- ReqWData  in  NREQ*DATA_W  packed write data, same packing
- Gnt  out  NREQ  one-hot, one-cycle grant acknowledge
- Done  out  NREQ  one-hot, one-cycle completion pulse
- RData  out  DATA_W  read data of the last completed read
- Busy  out  1  high while a transaction is in flight
- MemAccess  out  1  memory access enable
- MemRW  out  1  memory direction: 1 = write, 0 = read
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemRData  in  DATA_W  memory read data, registered inside the memory, valid one cycle after the access cycle

## Operation
- FSM states are IDLE, ACCESS and RESP. Transitions: IDLE→ACCESS when any Req bit is set; ACCESS→RESP unconditionally; RESP→IDLE unconditionally.
- Arbitration happens in IDLE only:
  - The winner is the first set Req bit at or above Ptr, searching upward modulo NREQ.
  - On the grant edge the arbiter latches Owner, ReqRW[Owner], ReqAddr[Owner] and ReqWData[Owner].
  - Ptr then becomes (Owner+1) mod NREQ.
- Ptr is unchanged when no request is granted. Its reset value is 0.
- ACCESS:
  - MemAccess=1.
  - MemRW, MemAddr and MemWData come from the latched registers.
  - Gnt[Owner]=1.
  - Busy=1.
- RESP:
  - MemAccess=0 and Busy=1.
  - On a read, MemRData is captured into RData at the end of RESP.
  - Done[Owner] is registered and goes high in the cycle after RESP, for both reads and writes.
- Requester protocol:
  - Hold Req, ReqRW, ReqAddr and ReqWData stable until Gnt is seen.
  - Deassert Req by the edge ending the Gnt cycle.
  - A Req still high when the FSM next samples in IDLE counts as a new request.
- RData holds its value across writes and idle periods. It changes only on read completion.
- Inputs of non-granted requesters are ignored. Changes to the owner's inputs after the grant edge have no effect on the transaction in flight.
- MemAddr, MemWData and MemRW hold their latched values outside ACCESS. They are meaningful only while MemAccess=1.

## Timing
- Reset values: state=IDLE, Ptr=0, Gnt=0, Done=0, RData=0, Busy=0, MemAccess=0, MemRW=0, MemAddr=0, MemWData=0.
- Latency, with Req sampled high at edge k in IDLE:
  - Gnt and MemAccess high in cycle k+1 (ACCESS).
  - RESP in cycle k+2.
  - Done high and RData valid in cycle k+3. The FSM is back in IDLE in that same cycle.
- Throughput: one transaction per 3 cycles. Back-to-back grants are possible because the IDLE cycle that shows Done also arbitrates.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait, and rotation guarantees each waits at most NREQ−1 transactions.
- Reset asserted mid-transaction:
  - The transaction is abandoned immediately and asynchronously.
  - No Done is produced and a partially sequenced access is not retried.
  - A write whose ACCESS edge has already occurred stays in memory.
- Gnt, Done and MemAccess are never high for more than one consecutive cycle per transaction.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the constants RW_WRITE=1 and RW_READ=0;
  - the default widths ADDR_W=8 and DATA_W=32.
- Sub-module rr_picker is combinational: given Req and Ptr it returns the winner index and a valid flag. The top module holds the FSM, Ptr, the latch registers and the output registers.

## Test plan
- Single write, then read: requester 0 writes addr 0x10, data 0xDEADBEEF. Required response: Gnt[0] at k+1 with MemAccess=1, MemRW=1, MemAddr=0x10; Done[0] at k+3. Requester 0 then reads 0x10 and gets Done[0] with RData=0xDEADBEEF.
- Contention: Req=2'b11 held continuously from reset with Ptr=0. Required grant order: 0,1,0,1 on cycles 1,4,7,10. Each Done follows its Gnt by 2 cycles.
- Rotation skip (NREQ=4): Ptr=2 and Req=4'b0011. Required: grant to requester 0 and Ptr becomes 1.
- Input change after grant: requester 1 reads 0x20, changing ReqAddr to 0x30 in the RESP cycle. Required: MemAddr=0x20 during ACCESS and RData=mem[0x20].
- Reset mid-transaction: Reset pulled low during RESP of a read. Required: all outputs 0 immediately, no Done, and the FSM in IDLE after release. A subsequent request completes normally.
- Idle hold: no requests for 20 cycles after a read returning 0x12345678. Required: Busy=0, MemAccess=0, and RData stays at 0x12345678.
